rr_grant_sequencer: RTL and testbench



---
 rtl/rr_grant_if.sv | 11 +
 rtl/rr_grant_sequencer.sv | 61 ++++++
 tb/tb_rr_grant_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/rr_grant_if.sv
// rr_grant_if: request/release and grant signals between requesters and rr_grant_sequencer
interface rr_grant_if;
  logic [15:0] req;
  logic        done;
  logic [3:0]  grant_idx;
  logic        grant_vld;
  logic        busy;
  logic        timeout;
  modport master (output req, done, input grant_idx, grant_vld, busy, timeout);
  modport slave (input req, done, output grant_idx, grant_vld, busy, timeout);
endinterface

// File: rtl/rr_grant_sequencer.sv
// rr_grant_sequencer: 16-way round-robin grant sequencer; define RR_GRANT_TIMEOUT_EN for MAX_HOLD forced release
module rr_grant_sequencer #(
  parameter int MAX_HOLD = 64
) (
  input logic       clk,
  input logic       rst_n,
  rr_grant_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t     state_q, state_d;
  logic [3:0] ptr_q, ptr_d, idx_q, idx_d, pick;
  logic [7:0] hold_q, hold_d;
  logic       vld_q, vld_d, busy_q, busy_d, to_q, to_d, rel, force_rel;
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 1..255");
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
    end
  end
  always_comb begin
    pick = ptr_q;
    for (int i = 15; i >= 0; i--)
      if (bus.req[ptr_q + 4'(i)]) pick = ptr_q + 4'(i);
    rel = bus.done || !bus.req[idx_q];
`ifdef RR_GRANT_TIMEOUT_EN
    force_rel = state_q == GRANT && !rel && hold_q == 8'(MAX_HOLD - 1);
`else
    force_rel = 1'b0;
`endif
    state_d = state_q == IDLE  ? (|bus.req ? GRANT : IDLE) :
              state_q == GRANT ? (rel || force_rel ? GAP : GRANT) : IDLE;
  end
  always_comb begin
    vld_d  = state_d == GRANT;
    busy_d = state_d != IDLE;
    to_d   = force_rel;
    idx_d  = state_q == IDLE && state_d == GRANT ? pick : idx_q;
    ptr_d  = state_q == GRANT && state_d == GAP ? idx_q + 4'd1 : ptr_q;
    hold_d = state_q != GRANT ? 8'd0 : hold_q + {7'd0, hold_q != 8'hFF};
  end
  assign bus.grant_idx = idx_q;
  assign bus.grant_vld = vld_q;
  assign bus.busy      = busy_q;
  assign bus.timeout   = to_q;
endmodule

// File: tb/tb_rr_grant_sequencer.sv
// tb_rr_grant_sequencer: directed checks of reset, grant, round-robin order, wrap and timeout
module tb_rr_grant_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  rr_grant_if bus ();
  rr_grant_sequencer #(.MAX_HOLD(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.done = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 16'hFFFF;
    bus.done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.grant_vld, bus.busy, bus.timeout, bus.grant_idx} !== 7'b000_0000) begin
        errors++;
        $display("FAIL reset cyc%0d: got vld/busy/to/idx=%b, expected 0000000", i,
                 {bus.grant_vld, bus.busy, bus.timeout, bus.grant_idx});
      end
    end
    rst_n = 1'b1;
    bus.req = '0;
    tick();
  endtask
  task automatic test_single();
    bus.req = 16'h0020;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.grant_vld, bus.busy, bus.grant_idx} !== {2'b11, 4'd5}) begin
        errors++;
        $display("FAIL single_grant cyc%0d: got vld/busy/idx=%b, expected 110101", i,
                 {bus.grant_vld, bus.busy, bus.grant_idx});
      end
      if (i < 2) tick();
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    checks++;
    if ({bus.grant_vld, bus.busy} !== 2'b01) begin
      errors++;
      $display("FAIL single_gap: got vld/busy=%b, expected 01", {bus.grant_vld, bus.busy});
    end
    tick();
    checks++;
    if ({bus.grant_vld, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_idle: got vld/busy=%b, expected 00", {bus.grant_vld, bus.busy});
    end
    tick();
    checks++;
    if ({bus.grant_vld, bus.grant_idx} !== {1'b1, 4'd5}) begin
      errors++;
      $display("FAIL single_regrant: got vld/idx=%b, expected 10101", {bus.grant_vld, bus.grant_idx});
    end
    bus.req = '0;
    tick();
    tick();
  endtask
  task automatic test_round_robin();
    logic [3:0] exp_order [5] = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd0};
    do_reset();
    bus.req = 16'h8421;
    for (int g = 0; g < 5; g++) begin
      tick();
      checks++;
      if ({bus.grant_vld, bus.grant_idx} !== {1'b1, exp_order[g]}) begin
        errors++;
        $display("FAIL rr_order grant%0d: got vld=%b idx=%0d, expected vld=1 idx=%0d", g,
                 bus.grant_vld, bus.grant_idx, exp_order[g]);
      end
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      checks++;
      if (bus.grant_vld !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap grant%0d: got vld=%b, expected 0", g, bus.grant_vld);
      end
      tick();
    end
    bus.req = '0;
    tick();
  endtask
  task automatic test_wrap_drop();
    do_reset();
    bus.req = 16'h4000;
    tick();
    checks++;
    if ({bus.grant_vld, bus.grant_idx} !== {1'b1, 4'd14}) begin
      errors++;
      $display("FAIL wrap_grant14: got vld/idx=%b, expected 11110", {bus.grant_vld, bus.grant_idx});
    end
    bus.req = '0;
    tick();
    checks++;
    if ({bus.grant_vld, bus.busy, bus.timeout, bus.grant_idx} !== {3'b010, 4'd14}) begin
      errors++;
      $display("FAIL drop_release: got vld/busy/to/idx=%b, expected 0101110",
               {bus.grant_vld, bus.busy, bus.timeout, bus.grant_idx});
    end
    tick();
    bus.req = 16'h0003;
    tick();
    checks++;
    if ({bus.grant_vld, bus.grant_idx} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL wrap_ptr15: got vld/idx=%b, expected 10000", {bus.grant_vld, bus.grant_idx});
    end
    bus.req = '0;
    tick();
    tick();
  endtask
  task automatic test_reset_mid_grant();
    do_reset();
    bus.req = 16'h0200;
    tick();
    checks++;
    if ({bus.grant_vld, bus.grant_idx} !== {1'b1, 4'd9}) begin
      errors++;
      $display("FAIL mid_grant9: got vld/idx=%b, expected 11001", {bus.grant_vld, bus.grant_idx});
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bus.grant_vld, bus.busy, bus.grant_idx} !== 6'b00_0000) begin
      errors++;
      $display("FAIL mid_reset: got vld/busy/idx=%b, expected 000000", {bus.grant_vld, bus.busy, bus.grant_idx});
    end
    rst_n = 1'b1;
    bus.req = 16'h0201;
    tick();
    checks++;
    if ({bus.grant_vld, bus.grant_idx} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL post_reset_ptr: got vld/idx=%b, expected 10000", {bus.grant_vld, bus.grant_idx});
    end
    bus.req = '0;
    tick();
    tick();
  endtask
  task automatic test_timeout();
    do_reset();
    bus.req = 16'h0008;
`ifdef RR_GRANT_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({bus.grant_vld, bus.timeout, bus.grant_idx} !== {2'b10, 4'd3}) begin
        errors++;
        $display("FAIL to_hold cyc%0d: got vld/to/idx=%b, expected 100011", i,
                 {bus.grant_vld, bus.timeout, bus.grant_idx});
      end
    end
    tick();
    checks++;
    if ({bus.grant_vld, bus.busy, bus.timeout} !== 3'b011) begin
      errors++;
      $display("FAIL to_pulse: got vld/busy/to=%b, expected 011", {bus.grant_vld, bus.busy, bus.timeout});
    end
    tick();
    checks++;
    if ({bus.grant_vld, bus.busy, bus.timeout} !== 3'b000) begin
      errors++;
      $display("FAIL to_idle: got vld/busy/to=%b, expected 000", {bus.grant_vld, bus.busy, bus.timeout});
    end
    tick();
    checks++;
    if ({bus.grant_vld, bus.timeout, bus.grant_idx} !== {2'b10, 4'd3}) begin
      errors++;
      $display("FAIL to_regrant: got vld/to/idx=%b, expected 100011", {bus.grant_vld, bus.timeout, bus.grant_idx});
    end
`else
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if ({bus.grant_vld, bus.timeout, bus.grant_idx} !== {2'b10, 4'd3}) begin
        errors++;
        $display("FAIL hold_forever cyc%0d: got vld/to/idx=%b, expected 100011", i,
                 {bus.grant_vld, bus.timeout, bus.grant_idx});
      end
    end
`endif
    bus.req = '0;
    tick();
    tick();
  endtask
  initial begin
    bus.req = '0;
    bus.done = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_drop();
    test_reset_mid_grant();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
